// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues {op,A,B} commands in a small FIFO and runs them one
// at a time on the ALU. Each command waits for done or a timeout, and its
// result (or an error) comes back on a valid/ready response channel.
module alu_op_sequencer #(
  parameter int ITEM_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [2:0]                    cmd_op_i,
  input  logic [ITEM_WIDTH-1:0]         cmd_a_i,
  input  logic [ITEM_WIDTH-1:0]         cmd_b_i,
  output logic                          alu_start_o,
  output logic [2:0]                    alu_op_o,
  output logic [ITEM_WIDTH-1:0]         alu_a_o,
  output logic [ITEM_WIDTH-1:0]         alu_b_o,
  input  logic                          alu_done_i,
  input  logic [2*ITEM_WIDTH-1:0]       alu_res_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [2*ITEM_WIDTH-1:0]       rsp_res_o,
  output logic                          rsp_err_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = 2*ITEM_WIDTH;
  localparam int EW = 3 + 2*ITEM_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push, pop;
  logic            start_d, rsp_valid_d, rsp_err_d;
  logic [RW-1:0]   rsp_res_d;

  // ready is registered, so a full FIFO cannot accept even when it pops
  assign push    = cmd_valid_i & cmd_ready_o;
  assign count_o = count_q;

  // Next-state and next registered outputs; one op in flight at a time
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_o;
    rsp_res_d   = rsp_res_o;
    rsp_err_d   = rsp_err_o;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // done takes priority over a timeout in the same cycle
        if (alu_done_i) begin
          rsp_res_d   = alu_res_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          rsp_res_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          // chain straight into the next op to avoid an idle bubble
          if (count_q != '0) begin
            pop     = 1'b1;
            start_d = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // State, FIFO control and all registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_ready_o <= 1'b0;
      alu_start_o <= 1'b0;
      alu_op_o    <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_res_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      cmd_ready_o <= (count_d < CW'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q                      <= rd_ptr_q + 1'b1;
        {alu_op_o, alu_a_o, alu_b_o}  <= mem[rd_ptr_q];
      end
      alu_start_o <= start_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_res_o   <= rsp_res_d;
      rsp_err_o   <= rsp_err_d;
    end
  end

  // Command storage; no reset needed, occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= {cmd_op_i, cmd_a_i, cmd_b_i};
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a transaction-level model predicts, every cycle,
// when each command should start, when and what its response is, and the FIFO
// occupancy. Directed scenarios run first, then a randomized soak.
module tb_alu_op_sequencer;
  localparam int IW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH+1);
  localparam int RW      = 2*IW;
  localparam int NEVER   = 1000000;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [2:0]    cmd_op_i = '0;
  logic [IW-1:0] cmd_a_i = '0;
  logic [IW-1:0] cmd_b_i = '0;
  logic          alu_start_o;
  logic [2:0]    alu_op_o;
  logic [IW-1:0] alu_a_o, alu_b_o;
  logic          alu_done_i = 1'b0;
  logic [RW-1:0] alu_res_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [RW-1:0] rsp_res_o;
  logic          rsp_err_o;
  logic [CW-1:0] count_o;

  alu_op_sequencer #(.ITEM_WIDTH(IW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .alu_start_o(alu_start_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_done_i(alu_done_i), .alu_res_i(alu_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_err_o(rsp_err_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // d = cycles from the start cycle to the done strobe (NEVER = no strobe)
  typedef struct { logic [2:0] op; logic [IW-1:0] a; logic [IW-1:0] b; int d; int acc; } cmd_t;
  typedef struct { logic [RW-1:0] res; logic err; } rsp_t;

  cmd_t stim_q[$];
  cmd_t fifo_q[$];
  rsp_t log_q[$];
  cmd_t cur;
  int   n = 0, start_cyc = -1, rsp_cyc = -1, done_cyc = -1;
  bit   eng_free = 1'b1, have_rsp = 1'b0, rst_cyc = 1'b0, rst_req = 1'b0;
  logic [RW-1:0] exp_res = '0, done_res = '0;
  logic exp_err = 1'b0;
  int   valid_pct = 100, rready_pct = 100, stray_pct = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, n, act, exp);
    end
  endtask

  // Behaviour of the ALU attached to the sequencer
  function automatic logic [RW-1:0] alu_ref(input logic [2:0] op, input logic [IW-1:0] a,
                                            input logic [IW-1:0] b);
    logic [RW-1:0] ea, eb;
    ea = RW'(a);
    eb = RW'(b);
    case (op)
      3'd1:    return ea + eb;
      3'd2:    return ea - eb;
      3'd3:    return ea * eb;
      3'd4:    return ea & eb;
      3'd5:    return ea ^ eb;
      default: return {a, b};
    endcase
  endfunction

  function automatic cmd_t mk(input logic [2:0] op, input logic [IW-1:0] a,
                              input logic [IW-1:0] b, input int d);
    cmd_t c;
    c.op = op; c.a = a; c.b = b; c.d = d; c.acc = -1;
    return c;
  endfunction

  function automatic int rand_d();
    int r;
    r = int'($urandom_range(15));
    if (r < 10)  return int'($urandom_range(1, 6));
    if (r == 10) return TIMEOUT;
    if (r == 11) return TIMEOUT - 1;
    if (r == 12) return TIMEOUT + 1;
    if (r == 13) return TIMEOUT + 2;
    if (r == 14) return NEVER;
    return 1;
  endfunction

  // One clock: entered and left at a negedge. Checks the current cycle
  // against the model, then drives inputs for the coming posedge.
  task automatic cycle();
    int   cnt;
    bit   vld_exp, st_exp, hs, stray_ok;
    cmd_t c;
    cnt = fifo_q.size();
    if (rst_cyc) begin
      chk("rst_alu", 32'({alu_start_o, alu_op_o, alu_a_o, alu_b_o}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid_o, rsp_err_o, rsp_res_o}), 32'd0);
      chk("rst_cmd", 32'({cmd_ready_o, count_o}), 32'd0);
      vld_exp = 1'b0;
    end else begin
      st_exp = (start_cyc == n);
      chk("start", 32'(alu_start_o), 32'(st_exp));
      if (!eng_free && n >= start_cyc)
        chk("alu_cmd", 32'({alu_op_o, alu_a_o, alu_b_o}), 32'({cur.op, cur.a, cur.b}));
      vld_exp = have_rsp && n >= rsp_cyc;
      chk("rsp_valid", 32'(rsp_valid_o), 32'(vld_exp));
      if (vld_exp) chk("rsp_data", 32'({rsp_err_o, rsp_res_o}), 32'({exp_err, exp_res}));
      chk("count", 32'(count_o), 32'(cnt));
      chk("cmd_ready", 32'(cmd_ready_o), 32'(cnt < DEPTH));
    end

    reset_i     = rst_req;
    rsp_ready_i = !rst_req && ($urandom_range(99) < rready_pct);
    hs = vld_exp && rsp_ready_i;
    if (hs) begin
      log_q.push_back('{rsp_res_o, rsp_err_o});
      have_rsp = 1'b0;
      eng_free = 1'b1;
    end

    // Strobes outside the wait window must be ignored
    stray_ok   = eng_free || (have_rsp && n >= rsp_cyc);
    alu_done_i = (n == done_cyc);
    alu_res_i  = alu_done_i ? done_res : RW'($urandom);
    if (!alu_done_i && stray_ok && $urandom_range(99) < stray_pct) alu_done_i = 1'b1;

    // Next command starts the cycle after the engine is free and one is queued
    if (!rst_req && eng_free && cnt > 0 && fifo_q[0].acc < n) begin
      cur       = fifo_q.pop_front();
      eng_free  = 1'b0;
      have_rsp  = 1'b1;
      start_cyc = n + 1;
      done_res  = alu_ref(cur.op, cur.a, cur.b);
      done_cyc  = (cur.d == NEVER) ? -1 : n + 1 + cur.d;
      if (cur.d <= TIMEOUT) begin
        exp_res = done_res; exp_err = 1'b0; rsp_cyc = n + 2 + cur.d;
      end else begin
        exp_res = '0;       exp_err = 1'b1; rsp_cyc = n + 2 + TIMEOUT;
      end
    end

    if (!rst_req && stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      c = stim_q[0];
      cmd_valid_i = 1'b1;
      cmd_op_i = c.op; cmd_a_i = c.a; cmd_b_i = c.b;
      if (!rst_cyc && cnt < DEPTH) begin
        void'(stim_q.pop_front());
        c.acc = n;
        fifo_q.push_back(c);
      end
    end else begin
      cmd_valid_i = 1'b0;
      cmd_op_i = 3'($urandom); cmd_a_i = IW'($urandom); cmd_b_i = IW'($urandom);
    end

    @(posedge clk_i);
    n++;
    if (rst_req) begin
      fifo_q.delete();
      have_rsp  = 1'b0;
      eng_free  = 1'b1;
      start_cyc = -1;
    end
    rst_cyc = rst_req;
    @(negedge clk_i);
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  initial begin
    cmd_t t2[$];
    int   k;
    @(posedge clk_i);
    @(negedge clk_i);
    n = 1; rst_cyc = 1'b1; rst_req = 1'b0;

    // Single add: start two cycles after acceptance, result 0x0046
    log_q.delete();
    stim_q.push_back(mk(3'd1, 8'h12, 8'h34, 3));
    run(10);
    chk("t1_nrsp", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) chk("t1_rsp", 32'({log_q[0].err, log_q[0].res}), 32'h0046);
    chk("t1_count", 32'(count_o), 32'd0);

    // Fill the FIFO behind a busy ALU with the response side stalled
    log_q.delete();
    rready_pct = 0;
    for (int i = 0; i < 6; i++) begin
      t2.push_back(mk(3'(i + 1), IW'(8'h21 * i), IW'(8'h13 + i), 6));
      stim_q.push_back(t2[i]);
    end
    run(8);
    chk("t2_full_count", 32'(count_o), 32'(DEPTH));
    chk("t2_full_ready", 32'(cmd_ready_o), 32'd0);
    chk("t2_held", 32'(stim_q.size()), 32'd1);
    rready_pct = 100;
    run(80);
    chk("t2_nrsp", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk("t2_order", 32'({log_q[i].err, log_q[i].res}),
          32'({1'b0, alu_ref(t2[i].op, t2[i].a, t2[i].b)}));

    // Timeout, then the next queued command runs normally
    log_q.delete();
    stim_q.push_back(mk(3'd2, 8'h50, 8'h20, NEVER));
    stim_q.push_back(mk(3'd3, 8'h0f, 8'h11, 2));
    run(TIMEOUT + 20);
    chk("t3_nrsp", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t3_timeout", 32'({log_q[0].err, log_q[0].res}), 32'h10000);
      chk("t3_next", 32'({log_q[1].err, log_q[1].res}), 32'h000ff);
    end

    // Response back-pressure holds the response and blocks new starts
    log_q.delete();
    rready_pct = 0;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(3'd5, IW'(8'h5a + i), 8'h0f, 2));
    run(16);
    chk("t4_blocked", 32'(log_q.size()), 32'd0);
    rready_pct = 100;
    run(25);
    chk("t4_nrsp", 32'(log_q.size()), 32'd3);

    // Reset mid-WAIT with two queued; the late done must be ignored
    log_q.delete();
    stim_q.push_back(mk(3'd1, 8'h01, 8'h02, 10));
    stim_q.push_back(mk(3'd1, 8'h03, 8'h04, 2));
    stim_q.push_back(mk(3'd1, 8'h05, 8'h06, 2));
    run(6);
    chk("t5_queued", 32'(count_o), 32'd2);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    run(20);
    chk("t5_nrsp", 32'(log_q.size()), 32'd0);
    chk("t5_count", 32'(count_o), 32'd0);

    // Done on the last wait cycle wins; one cycle later is a timeout
    log_q.delete();
    stim_q.push_back(mk(3'd4, 8'hf0, 8'h3c, TIMEOUT));
    stim_q.push_back(mk(3'd5, 8'haa, 8'h55, TIMEOUT + 1));
    run(50);
    chk("t6_nrsp", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t6_edge_done", 32'({log_q[0].err, log_q[0].res}), 32'h00030);
      chk("t6_late_done", 32'({log_q[1].err, log_q[1].res}), 32'h10000);
    end

    // Randomized soak with gaps, back-pressure and stray strobes
    valid_pct = 60; rready_pct = 70; stray_pct = 10;
    repeat (1500) begin
      if (stim_q.size() < 2)
        stim_q.push_back(mk(3'($urandom), IW'($urandom), IW'($urandom), rand_d()));
      cycle();
    end
    stray_pct = 0; valid_pct = 100; rready_pct = 100;
    k = 0;
    while ((stim_q.size() > 0 || fifo_q.size() > 0 || have_rsp) && k < 600) begin
      cycle();
      k++;
    end
    chk("drain", 32'(stim_q.size() + fifo_q.size() + int'(have_rsp)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
